// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared types, glyph constants and font address helper for the HUD digit converter
package hud_pkg;

  typedef logic [10:0] font_addr_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         GLYPH_SHIFT = 4;

  localparam font_addr_t SPACE_ADDR = font_addr_t'(ASCII_SPACE) << GLYPH_SHIFT;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_t;

  // Glyph base address of a decimal digit: {ASCII, 4'b0}
  function automatic font_addr_t to_font_addr(input logic [3:0] nibble);
    logic [7:0] ch;
    ch = ASCII_ZERO + {4'h0, nibble};
    return font_addr_t'(ch) << GLYPH_SHIFT;
  endfunction

endpackage

// File: rtl/bcd_dabble.sv
// rtl/bcd_dabble.sv - shift-add-3 binary to BCD datapath, one bit per enabled cycle
module bcd_dabble #(
  parameter int IN_WIDTH = 16,
  parameter int BCD_N    = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [IN_WIDTH-1:0]   operand,
  input  logic                  shift_en,
  output logic [4*BCD_N-1:0]    bcd
);

  logic [IN_WIDTH-1:0] bin;
  logic [4*BCD_N-1:0]  adj;

  // Add 3 to every nibble above 4 so the following shift carries correctly into the next decade
  always_comb begin
    adj = bcd;
    for (int k = 0; k < BCD_N; k++) begin
      if (bcd[4*k +: 4] > 4'd4) begin
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Load clears the BCD accumulator; each shift moves the binary MSB into the BCD LSB
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bin <= '0;
      bcd <= '0;
    end else if (load) begin
      bin <= operand;
      bcd <= '0;
    end else if (shift_en) begin
      bcd <= {adj[4*BCD_N-2:0], bin[IN_WIDTH-1]};
      bin <= {bin[IN_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hud_digit_converter.sv
// rtl/hud_digit_converter.sv - per-frame score/lives/level to font glyph addresses (option: HUD_LEADING_BLANK_EN)
module hud_digit_converter
  import hud_pkg::*;
#(
  parameter int IN_WIDTH     = 16,
  parameter int SCORE_DIGITS = 4,
  parameter int SMALL_DIGITS = 2
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic                                frame_tick,
  input  logic [IN_WIDTH-1:0]                 ScoreInt,
  input  logic [IN_WIDTH-1:0]                 LivesInt,
  input  logic [IN_WIDTH-1:0]                 LevelInt,
  output font_addr_t [SCORE_DIGITS-1:0]       ScoreDigits,
  output font_addr_t [SMALL_DIGITS-1:0]       LivesDigits,
  output font_addr_t [SMALL_DIGITS-1:0]       LevelDigits,
  output logic                                busy,
  output logic                                done
);

  localparam int BCD_N = (IN_WIDTH + 2) / 3;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  conv_state_t          state, state_next;
  logic [CNT_W-1:0]     shift_cnt;
  logic [1:0]           op_idx;
  logic [IN_WIDTH-1:0]  score_q, lives_q, level_q;
  logic [IN_WIDTH-1:0]  operand;
  logic [BCD_W-1:0]     eng_bcd;
  logic [BCD_W-1:0]     shadow_score, shadow_lives;
  logic                 eng_load, eng_shift, last_shift;

  // Value shown on a digit while nothing has been converted yet
  function automatic font_addr_t reset_digit(input int i);
`ifdef HUD_LEADING_BLANK_EN
    return (i == 0) ? to_font_addr(4'd0) : SPACE_ADDR;
`else
    if (i < 0) return SPACE_ADDR;
    return to_font_addr(4'd0);
`endif
  endfunction

  // Glyph for digit i of an n-digit field: saturate to 9s on overflow, optional leading blanks
  function automatic font_addr_t field_digit(input logic [BCD_W-1:0] val, input int n, input int i);
    logic sat;
`ifdef HUD_LEADING_BLANK_EN
    logic lead_zero;
`endif
    sat = 1'b0;
    for (int k = 0; k < BCD_N; k++) begin
      if (k >= n && val[4*k +: 4] != 4'd0) sat = 1'b1;
    end
    if (sat) return to_font_addr(4'd9);
`ifdef HUD_LEADING_BLANK_EN
    lead_zero = (i != 0);
    for (int k = 0; k < BCD_N; k++) begin
      if (k >= i && k < n && val[4*k +: 4] != 4'd0) lead_zero = 1'b0;
    end
    if (lead_zero) return SPACE_ADDR;
`endif
    return to_font_addr(val[4*i +: 4]);
  endfunction

  assign last_shift = (shift_cnt == CNT_W'(IN_WIDTH - 1));

  // Operand order through the shared engine: score, lives, level
  always_comb begin
    operand = score_q;
    case (op_idx)
      2'd1:    operand = lives_q;
      2'd2:    operand = level_q;
      default: operand = score_q;
    endcase
  end

  bcd_dabble #(
    .IN_WIDTH (IN_WIDTH),
    .BCD_N    (BCD_N)
  ) u_engine (
    .clk      (Clk),
    .resetn   (Reset_n),
    .load     (eng_load),
    .operand  (operand),
    .shift_en (eng_shift),
    .bcd      (eng_bcd)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and engine controls
  always_comb begin
    state_next = state;
    eng_load   = 1'b0;
    eng_shift  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_tick) state_next = LOAD;
      end
      LOAD: begin
        eng_load   = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        eng_shift = 1'b1;
        if (last_shift) state_next = (op_idx == 2'd2) ? COMMIT : LOAD;
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture, shift counting and shadowing of finished operands (stored as the next one loads)
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      score_q      <= '0;
      lives_q      <= '0;
      level_q      <= '0;
      shift_cnt    <= '0;
      op_idx       <= '0;
      shadow_score <= '0;
      shadow_lives <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            score_q   <= ScoreInt;
            lives_q   <= LivesInt;
            level_q   <= LevelInt;
            op_idx    <= '0;
            shift_cnt <= '0;
          end
        end
        LOAD: begin
          if (op_idx == 2'd1) shadow_score <= eng_bcd;
          if (op_idx == 2'd2) shadow_lives <= eng_bcd;
        end
        SHIFT: begin
          if (last_shift) begin
            shift_cnt <= '0;
            op_idx    <= op_idx + 2'd1;
          end else begin
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers update together in COMMIT; level comes straight from the engine
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      done <= 1'b0;
      for (int i = 0; i < SCORE_DIGITS; i++) ScoreDigits[i] <= reset_digit(i);
      for (int i = 0; i < SMALL_DIGITS; i++) LivesDigits[i] <= reset_digit(i);
      for (int i = 0; i < SMALL_DIGITS; i++) LevelDigits[i] <= reset_digit(i);
    end else begin
      done <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int i = 0; i < SCORE_DIGITS; i++)
          ScoreDigits[i] <= field_digit(shadow_score, SCORE_DIGITS, i);
        for (int i = 0; i < SMALL_DIGITS; i++)
          LivesDigits[i] <= field_digit(shadow_lives, SMALL_DIGITS, i);
        for (int i = 0; i < SMALL_DIGITS; i++)
          LevelDigits[i] <= field_digit(eng_bcd, SMALL_DIGITS, i);
      end
    end
  end

endmodule

// File: tb/tb_hud_digit_converter.sv
// tb/tb_hud_digit_converter.sv - self-checking bench for hud_digit_converter (honours HUD_LEADING_BLANK_EN)
module tb_hud_digit_converter;
  import hud_pkg::*;

  localparam int SD = 4;
  localparam int MD = 2;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic                 frame_tick = 1'b0;
  logic [15:0]          ScoreInt = '0, LivesInt = '0, LevelInt = '0;
  font_addr_t [SD-1:0]  ScoreDigits;
  font_addr_t [MD-1:0]  LivesDigits;
  font_addr_t [MD-1:0]  LevelDigits;
  logic                 busy, done;

  int checks = 0;
  int errors = 0;

  hud_digit_converter dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_tick  (frame_tick),
    .ScoreInt    (ScoreInt),
    .LivesInt    (LivesInt),
    .LevelInt    (LevelInt),
    .ScoreDigits (ScoreDigits),
    .LivesDigits (LivesDigits),
    .LevelDigits (LevelDigits),
    .busy        (busy),
    .done        (done)
  );

  always #5 Clk = ~Clk;

  function automatic int pow10(input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digit i of v shown in an n-digit field
  function automatic logic [10:0] exp_field(input int v, input int n, input int i);
    int d;
    if (v > pow10(n) - 1) return 11'h390;
    d = (v / pow10(i)) % 10;
`ifdef HUD_LEADING_BLANK_EN
    if (i > 0 && v < pow10(i)) return 11'h200;
`endif
    return 11'h300 + 11'(d * 16);
  endfunction

  function automatic logic [10:0] exp_reset(input int i);
`ifdef HUD_LEADING_BLANK_EN
    return (i == 0) ? 11'h300 : 11'h200;
`else
    return (i < 0) ? 11'h200 : 11'h300;
`endif
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_digits(input int s, input int l, input int v);
    for (int i = 0; i < SD; i++) check("score_digit", i, 32'(ScoreDigits[i]), 32'(exp_field(s, SD, i)));
    for (int i = 0; i < MD; i++) check("lives_digit", i, 32'(LivesDigits[i]), 32'(exp_field(l, MD, i)));
    for (int i = 0; i < MD; i++) check("level_digit", i, 32'(LevelDigits[i]), 32'(exp_field(v, MD, i)));
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < SD; i++) check("rst_score", i, 32'(ScoreDigits[i]), 32'(exp_reset(i)));
    for (int i = 0; i < MD; i++) check("rst_lives", i, 32'(LivesDigits[i]), 32'(exp_reset(i)));
    for (int i = 0; i < MD; i++) check("rst_level", i, 32'(LevelDigits[i]), 32'(exp_reset(i)));
    check("rst_busy", 0, 32'(busy), 32'd0);
    check("rst_done", 0, 32'(done), 32'd0);
  endtask

  // Pulse frame_tick, expect done exactly 52 edges after the capture edge, then a single pulse
  task automatic run_conv(input int s, input int l, input int v);
    int lat = -1;
    @(negedge Clk);
    ScoreInt = 16'(s); LivesInt = 16'(l); LevelInt = 16'(v);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    check("busy_after_capture", 0, 32'(busy), 32'd1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge Clk);
      if (k == 51) check("busy_in_commit", k, 32'(busy), 32'd1);
      if (done) begin lat = k; break; end
    end
    check("latency", 0, 32'(lat), 32'd52);
    check_digits(s, l, v);
    @(negedge Clk);
    check("done_one_cycle", 0, 32'(done), 32'd0);
    check("busy_idle", 0, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, ndone, s, l, v;

    // Reset
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_reset_state();

    // Nominal conversion with literal spot checks
    run_conv(1234, 3, 12);
    check("lit_score3", 3, 32'(ScoreDigits[3]), 32'h310);
    check("lit_score0", 0, 32'(ScoreDigits[0]), 32'h340);
    check("lit_level1", 1, 32'(LevelDigits[1]), 32'h310);
    check("lit_level0", 0, 32'(LevelDigits[0]), 32'h320);

    // Saturation and exact upper boundaries
    run_conv(12345, 100, 99);
    run_conv(9999, 99, 0);
    run_conv(10000, 0, 65535);
    run_conv(7, 10, 1);
    run_conv(0, 0, 0);

    // Tick during conversion ignored, input change after capture ignored
    @(negedge Clk);
    ScoreInt = 16'd4321; LivesInt = 16'd5; LevelInt = 16'd67;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    lat = -1; ndone = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge Clk);
      if (k == 5)  ScoreInt = 16'd8888;
      if (k == 10) frame_tick = 1'b1;
      if (k == 11) frame_tick = 1'b0;
      if (done) begin ndone++; if (lat < 0) lat = k; end
    end
    check("drop_latency", 0, 32'(lat), 32'd52);
    check("drop_done_count", 0, 32'(ndone), 32'd1);
    check_digits(4321, 5, 67);

    // Reset mid-conversion
    @(negedge Clk);
    ScoreInt = 16'd555; LivesInt = 16'd44; LevelInt = 16'd33;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (20) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check_reset_state();
    ndone = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge Clk);
      if (done) ndone++;
    end
    check("no_done_after_reset", 0, 32'(ndone), 32'd0);
    check_reset_state();
    run_conv(555, 44, 33);

    // Randomized values against the arithmetic reference
    for (int n = 0; n < 10; n++) begin
      case (n % 3)
        0:       begin s = $urandom_range(0, 99);    l = $urandom_range(0, 9);   v = $urandom_range(0, 15); end
        1:       begin s = $urandom_range(0, 9999);  l = $urandom_range(0, 99);  v = $urandom_range(0, 99); end
        default: begin s = $urandom_range(0, 65535); l = $urandom_range(0, 300); v = $urandom_range(0, 65535); end
      endcase
      run_conv(s, l, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
